// File: rtl/wb_pc_update.sv
// Write-back / PC-update stage of the Y86-64 SEQ core: register file, architectural PC, status latch and retire counter.
// Latency: commits on the rising edge after inputs settle; read ports valA/valB are combinational (optional write-through).
// Backpressure: stall=1 holds all state for the cycle; any non-AOK status freezes the stage in HALT until rst.
module wb_pc_update #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32,
  parameter bit          BYPASS   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic [3:0]       dstE,
  input  logic [3:0]       dstM,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  input  logic [63:0]      valC,
  input  logic [63:0]      valP,
  input  logic [3:0]       stat_in,
  input  logic             stall,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [63:0]      valA,
  output logic [63:0]      valB,
  output logic [63:0]      pc,
  output logic [3:0]       stat_out,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  // Instruction codes that affect write-back or PC selection.
  localparam logic [3:0] ICMOV = 4'h2;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  // Register index meaning "no register".
  localparam logic [3:0] RNONE = 4'hF;

  // Status encodings.
  localparam logic [3:0] SAOK = 4'd0;
  localparam logic [3:0] SINS = 4'd3;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic              commit;
  logic              fault;
  logic              weE;
  logic              weM;
  logic [3:0]        statNorm;
  logic [63:0]       newPc;
  logic [63:0]       regFile [15];

  // Fold the undefined status codes 4..15 onto INS.
  always_comb begin
    statNorm = stat_in;
    if (stat_in > SINS) begin
      statNorm = SINS;
    end
  end

  // State register: RUN until a faulting status arrives, then HALT until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: decide whether this cycle commits, faults, or holds.
  always_comb begin
    stateNext = state;
    commit    = 1'b0;
    fault     = 1'b0;
    case (state)
      RUN: begin
        // rst gating keeps the write-through path quiet while reset is held.
        if (!rst && !stall) begin
          if (statNorm == SAOK) begin
            commit = 1'b1;
          end else begin
            fault     = 1'b1;
            stateNext = HALT;
          end
        end
      end
      HALT: begin
        stateNext = HALT;
      end
      default: begin
        stateNext = HALT;
      end
    endcase
  end

  // Write enables: a failed cmov drops the E write; when both ports target
  // the same register only the M write happens so the memory value wins.
  always_comb begin
    weM = commit && (dstM != RNONE);
    weE = commit && (dstE != RNONE) && !((icode == ICMOV) && !cnd) && !(weM && (dstE == dstM));
  end

  // Next-PC selection: call and taken jumps go to valC, ret to the popped address.
  always_comb begin
    newPc = valP;
    case (icode)
      ICALL:   newPc = valC;
      IJXX:    newPc = cnd ? valC : valP;
      IRET:    newPc = valM;
      default: newPc = valP;
    endcase
  end

  // Register file: two write ports, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regFile[i] <= 64'd0;
      end
    end else begin
      if (weE) begin
        regFile[dstE] <= valE;
      end
      if (weM) begin
        regFile[dstM] <= valM;
      end
    end
  end

  // Architectural PC advances only on a committed instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (commit) begin
      pc <= newPc;
    end
  end

  // Retire counter wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (commit) begin
      retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Status latch captures the faulting status once, on the way into HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_out <= SAOK;
    end else if (fault) begin
      stat_out <= statNorm;
    end
  end

  assign halted = (state == HALT);

  // Read port A: index F reads zero; optional write-through, valM before valE.
  always_comb begin
    valA = 64'd0;
    if (srcA != RNONE) begin
      if (BYPASS && weM && (dstM == srcA)) begin
        valA = valM;
      end else if (BYPASS && weE && (dstE == srcA)) begin
        valA = valE;
      end else begin
        valA = regFile[srcA];
      end
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    valB = 64'd0;
    if (srcB != RNONE) begin
      if (BYPASS && weM && (dstM == srcB)) begin
        valB = valM;
      end else if (BYPASS && weE && (dstE == srcB)) begin
        valB = valE;
      end else begin
        valB = regFile[srcB];
      end
    end
  end

endmodule

// File: tb/tb_wb_pc_update.sv
// Bench for wb_pc_update: two instances (store-only reads with a narrow counter, write-through reads with a wide counter)
// share one stimulus stream; a behavioural model queues the expected observation each cycle and a monitor compares it.
// Directed scenarios first, then randomized instructions with occasional faults and reset pulses.
module tb_wb_pc_update;

  localparam logic [63:0] RPC = 64'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode;
  logic        cnd;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [3:0]  statIn;
  logic        stall;
  logic [3:0]  srcA;
  logic [3:0]  srcB;

  logic [63:0] valA0, valB0, pc0, valA1, valB1, pc1;
  logic [3:0]  stat0, stat1;
  logic        halted0, halted1;
  logic [3:0]  retired0;
  logic [31:0] retired1;

  wb_pc_update #(.RESET_PC(RPC), .CNT_W(4), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .icode(icode), .cnd(cnd), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .valC(valC), .valP(valP), .stat_in(statIn), .stall(stall),
    .srcA(srcA), .srcB(srcB), .valA(valA0), .valB(valB0), .pc(pc0),
    .stat_out(stat0), .halted(halted0), .retired(retired0)
  );

  wb_pc_update #(.RESET_PC(RPC), .CNT_W(32), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .icode(icode), .cnd(cnd), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .valC(valC), .valP(valP), .stat_in(statIn), .stall(stall),
    .srcA(srcA), .srcB(srcB), .valA(valA1), .valB(valB1), .pc(pc1),
    .stat_out(stat1), .halted(halted1), .retired(retired1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a0, b0, a1, b1;
    logic [63:0] pc;
    logic [3:0]  stat;
    logic        halted;
    int unsigned ret;
  } obsT;

  obsT expQ[$];

  // Architectural model state.
  logic [63:0] mReg [15];
  logic [63:0] mPc;
  logic [3:0]  mStat;
  logic        mHalt;
  int unsigned mRet;

  int nCmp = 0;
  int nBad = 0;
  bit driverDone = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 15; i++) mReg[i] = 64'd0;
    mPc   = RPC;
    mStat = 4'd0;
    mHalt = 1'b0;
    mRet  = 0;
  endfunction

  // Read as seen by decode this cycle; with write-through a pending write is visible.
  function automatic logic [63:0] modelRead(input logic [3:0] idx, input bit wt, input bit doCommit);
    logic eE, eM;
    if (idx == 4'hF) return 64'd0;
    eM = doCommit && (dstM != 4'hF);
    eE = doCommit && (dstE != 4'hF) && !(icode == 4'h2 && !cnd);
    if (wt && eM && dstM == idx) return valM;
    if (wt && eE && dstE == idx) return valE;
    return mReg[idx];
  endfunction

  // Drive one cycle of stimulus, queue the expected observation, then advance the model.
  task automatic cyc(input logic r, input logic [3:0] ic, input logic c,
                     input logic [3:0] de, input logic [3:0] dm,
                     input logic [63:0] ve, input logic [63:0] vm,
                     input logic [63:0] vc, input logic [63:0] vp,
                     input logic [3:0] st, input logic sl,
                     input logic [3:0] sa, input logic [3:0] sb);
    obsT o;
    bit doCommit;
    @(negedge clk);
    rst = r; icode = ic; cnd = c; dstE = de; dstM = dm;
    valE = ve; valM = vm; valC = vc; valP = vp; statIn = st; stall = sl;
    srcA = sa; srcB = sb;
    if (r) modelReset();
    doCommit = !r && !mHalt && !sl && (st == 4'd0);
    o.a0 = modelRead(sa, 1'b0, doCommit);
    o.b0 = modelRead(sb, 1'b0, doCommit);
    o.a1 = modelRead(sa, 1'b1, doCommit);
    o.b1 = modelRead(sb, 1'b1, doCommit);
    o.pc = mPc; o.stat = mStat; o.halted = mHalt; o.ret = mRet;
    expQ.push_back(o);
    if (!r && !mHalt && !sl) begin
      if (st == 4'd0) begin
        if (de != 4'hF && !(ic == 4'h2 && !c)) mReg[de] = ve;
        if (dm != 4'hF) mReg[dm] = vm;
        case (ic)
          4'h8:    mPc = vc;
          4'h7:    mPc = c ? vc : vp;
          4'h9:    mPc = vm;
          default: mPc = vp;
        endcase
        mRet++;
      end else begin
        mStat = (st > 4'd3) ? 4'd3 : st;
        mHalt = 1'b1;
      end
    end
  endtask

  // Monitor: each observation window sits 2 time units after the falling edge.
  initial begin
    obsT o;
    forever begin
      @(negedge clk);
      #2;
      while (expQ.size() > 0) begin
        o = expQ.pop_front();
        chk("valA_store", valA0, o.a0);
        chk("valB_store", valB0, o.b0);
        chk("valA_wthru", valA1, o.a1);
        chk("valB_wthru", valB1, o.b1);
        chk("pc0", pc0, o.pc);
        chk("pc1", pc1, o.pc);
        chk("stat0", {60'd0, stat0}, {60'd0, o.stat});
        chk("stat1", {60'd0, stat1}, {60'd0, o.stat});
        chk("halted0", {63'd0, halted0}, {63'd0, o.halted});
        chk("halted1", {63'd0, halted1}, {63'd0, o.halted});
        chk("retired_w4", {60'd0, retired0}, {60'd0, 4'(o.ret)});
        chk("retired_w32", {32'd0, retired1}, {32'd0, o.ret});
      end
    end
  end

  initial begin
    logic [3:0] ic, de, dm, st, sa, sb;
    modelReset();
    rst = 1'b1; icode = 4'h1; cnd = 1'b0; dstE = 4'hF; dstM = 4'hF;
    valE = '0; valM = '0; valC = '0; valP = '0; statIn = '0; stall = 1'b0;
    srcA = 4'hF; srcB = 4'hF;

    // Reset and the directed scenarios.
    cyc(1, 4'h1, 0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0, 4'hF);
    cyc(1, 4'h1, 0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0, 4'h1);
    cyc(0, 4'h3, 0, 4'h0, 4'hF, 64'h1234, 0, 0, 64'd10, 0, 0, 4'h0, 4'h1);
    cyc(0, 4'h7, 1, 4'hF, 4'hF, 0, 0, 64'h100, 64'h9, 0, 0, 4'h0, 4'hF);
    cyc(0, 4'h7, 0, 4'hF, 4'hF, 0, 0, 64'h100, 64'h9, 0, 0, 4'h0, 4'hF);
    cyc(0, 4'h9, 1, 4'h4, 4'hF, 64'h208, 64'h40, 0, 64'h11, 0, 0, 4'h4, 4'h0);
    cyc(0, 4'h5, 0, 4'h3, 4'h3, 64'd1, 64'd2, 0, 64'h20, 0, 0, 4'h4, 4'h3);
    cyc(0, 4'h2, 0, 4'h3, 4'hF, 64'hdead, 0, 0, 64'h30, 0, 0, 4'h3, 4'h4);
    cyc(0, 4'h8, 1, 4'h7, 4'h8, 64'h77, 64'h88, 64'h500, 64'h40, 0, 1, 4'h7, 4'h8);
    cyc(0, 4'h8, 1, 4'h7, 4'h8, 64'h77, 64'h88, 64'h500, 64'h40, 0, 1, 4'h7, 4'h8);
    cyc(0, 4'h8, 1, 4'h7, 4'h8, 64'h77, 64'h88, 64'h500, 64'h40, 0, 1, 4'h7, 4'h8);
    cyc(0, 4'h6, 0, 4'h5, 4'hF, 64'h55, 0, 0, 64'h42, 0, 0, 4'h5, 4'h3);
    cyc(0, 4'h6, 0, 4'h1, 4'hF, 64'h99, 0, 0, 64'h44, 4'd2, 0, 4'h5, 4'h1);
    cyc(0, 4'h6, 0, 4'h1, 4'h2, 64'h98, 64'h97, 0, 64'h46, 0, 0, 4'h1, 4'h2);
    cyc(0, 4'h6, 0, 4'h1, 4'h2, 64'h98, 64'h97, 0, 64'h46, 0, 1, 4'h1, 4'h2);
    cyc(1, 4'h6, 0, 4'h1, 4'h2, 64'h98, 64'h97, 0, 64'h46, 0, 1, 4'h5, 4'h0);
    cyc(0, 4'h0, 0, 4'hF, 4'hF, 0, 0, 0, 64'h1001, 4'd1, 0, 4'h5, 4'h0);
    cyc(0, 4'h3, 0, 4'h2, 4'hF, 64'h5, 0, 0, 64'h1002, 0, 0, 4'h2, 4'h0);
    cyc(1, 4'h3, 0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 4'h2, 4'h0);
    cyc(0, 4'h3, 0, 4'h2, 4'hF, 64'h5, 0, 0, 64'h1002, 4'd12, 0, 4'h2, 4'h0);
    cyc(1, 4'h3, 0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 4'h2, 4'h0);

    // Randomized phase: long enough to wrap the narrow counter several times.
    for (int n = 0; n < 1500; n++) begin
      ic = 4'($urandom_range(0, 11));
      de = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      dm = ($urandom_range(0, 2) != 0) ? 4'hF : (($urandom_range(0, 3) == 0) ? de : 4'($urandom_range(0, 14)));
      st = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      sa = ($urandom_range(0, 2) == 0) ? de : 4'($urandom_range(0, 15));
      sb = ($urandom_range(0, 2) == 0) ? dm : 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 99) == 0) || (mHalt && $urandom_range(0, 9) == 0),
          ic, 1'($urandom), de, dm,
          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          st, ($urandom_range(0, 4) == 0), sa, sb);
    end

    cyc(0, 4'h1, 0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 1, 4'h0, 4'h1);
    @(negedge clk);
    @(negedge clk);
    #4;
    if (expQ.size() != 0) begin
      nBad++;
      $display("FAIL drain: %0d observations left unchecked, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/wb_pc_update.md
Name: wb_pc_update

Overview:
- Write-back and PC-update stage of the Y86-64 SEQ processor, directly downstream of the data-memory stage.
- Holds the 15-entry 64-bit register file and the architectural PC.
- Commits valE/valM to the register file and selects the next PC.
- Latches the processor status and freezes the machine on any non-AOK status.
- Also supplies the combinational register read ports used by decode.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter
BYPASS, 0, 1 = read ports see same-cycle write data (write-through); 0 = reads return stored value only

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
icode  input  4  current instruction code
cnd  input  1  condition flag from execute (jXX / cmovXX)
dstE  input  4  destination for valE; 4'hF = none
dstM  input  4  destination for valM; 4'hF = none
valE  input  64  ALU result
valM  input  64  data-memory read value
valC  input  64  instruction constant
valP  input  64  fall-through PC
stat_in  input  4  status from memory stage: 0 AOK, 1 HLT, 2 ADR, 3 INS
stall  input  1  hold all state this cycle (no write, no PC change, no count)
srcA  input  4  read port A index; 4'hF returns 0
srcB  input  4  read port B index; 4'hF returns 0
valA  output  64  register[srcA], combinational
valB  output  64  register[srcB], combinational
pc  output  64  current PC
stat_out  output  4  latched processor status
halted  output  1  1 when in HALT state
retired  output  CNT_W  count of committed instructions

Behaviour:
- Reset (async, immediate): all 15 registers = 0; pc = RESET_PC; state RUN; stat_out = 0; halted = 0; retired = 0.
- Two states: RUN and HALT. HALT is left only by rst.
- RUN, stall = 1: no state change.
- RUN, stall = 0, stat_in = AOK, commit on the rising edge:
  - Write valE to dstE when dstE != F.
  - Write valM to dstM when dstM != F.
  - Update pc to new_pc.
  - retired += 1, wraps modulo 2^CNT_W.
- cmovXX (icode 2) with cnd = 0: the dstE write is suppressed; PC still advances to valP.
- dstE == dstM, both != F: the valM write wins; exactly one write occurs.
- new_pc selection:
  - icode 8 (call) -> valC.
  - icode 7 (jXX) -> valC if cnd, else valP.
  - icode 9 (ret) -> valM.
  - All others -> valP.
- RUN, stall = 0, stat_in != AOK, on the edge:
  - No register writes; pc unchanged; retired unchanged.
  - stat_out = stat_in, halted = 1, enter HALT.
  - HLT is therefore not counted as retired.
- HALT: all inputs ignored (including stall); pc, registers, retired and stat_out all hold.
- stat_in encodings 4..15 are treated as INS: stat_out = 3.
- Reads, BYPASS = 0: valA/valB return the stored register contents.
- Reads, BYPASS = 1: when a read index matches an enabled write this cycle, the port returns the write data; valM has priority over valE.
- Index F on either read port always returns 64'd0.
- rst asserted mid-cycle: state clears immediately regardless of stall or halted. The first edge after rst deasserts commits normally.

Test Plan:
- Reset, then commit icode 3 with dstE = 0, valE = 64'h1234, valP = 10 -> reg0 = 64'h1234, pc = 10, retired = 1, stat_out = 0.
- icode 7 with valC = 64'h100, valP = 64'h9: cnd = 1 -> pc = 64'h100; cnd = 0 -> pc = 64'h9.
- icode 9 (ret) with valM = 64'h40, dstE = 4 (rsp), valE = 64'h208 -> pc = 64'h40, reg4 = 64'h208.
- icode 5 with dstE = dstM = 3, valE = 1, valM = 2 -> reg3 = 2.
- cmov (icode 2), cnd = 0 -> dstE register unchanged, pc = valP.
- stat_in = 2 (ADR) with dstE = 1 -> reg1 unchanged, pc unchanged, halted = 1, stat_out = 2. Further AOK commits are ignored until rst.
- stall = 1 for 3 cycles with valid writes -> no change.
- With BYPASS = 1: srcA = dstE = 5 in the same cycle -> valA = valE.
- rst pulse while halted -> pc = RESET_PC, halted = 0, all registers 0.
